// File: rtl/eth_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : eth_frame_tx
// Purpose  : Packetiser for the 1G RGMII MAC transmit AXI-Stream port.
//            Payload bytes from the adc_buffer stream are collected in an
//            internal FIFO. Once PAYLOAD_LEN bytes are held, one raw
//            Ethernet II frame is sent: DST_MAC, SRC_MAC, EtherType,
//            optional 16-bit sequence number, then PAYLOAD_LEN bytes.
//            The MAC adds the preamble, padding and FCS.
// Config   : define ETH_FRAME_TX_SEQ_EN to insert a big-endian 16-bit
//            sequence counter after the EtherType (header is 16 bytes).
//            Without it the header is 14 bytes and has no sequence logic.
// Ports    : clk            - 125 MHz clock (clk_125m)
//            reset          - asynchronous, active-high reset
//            enable         - allow new frames to start
//            din/din_valid  - payload byte stream, no backpressure
//            tx_axis_*      - AXI-Stream master toward the MAC (tuser tied 0)
//            fifo_overflow  - sticky, a din byte was dropped on a full FIFO
//            frame_count    - number of completed frames, wraps
//            busy           - a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module eth_frame_tx #(
   parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
   parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETHERTYPE   = 16'h88B5,
   parameter int          PAYLOAD_LEN = 1024,
   parameter int          FIFO_AW     = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  din,
   input  logic        din_valid,
   output logic [7:0]  tx_axis_tdata,
   output logic        tx_axis_tvalid,
   input  logic        tx_axis_tready,
   output logic        tx_axis_tlast,
   output logic        tx_axis_tuser,
   output logic        fifo_overflow,
   output logic [15:0] frame_count,
   output logic        busy
);

`ifdef ETH_FRAME_TX_SEQ_EN
   localparam int HDR_LEN = 16;
`else
   localparam int HDR_LEN = 14;
`endif
   localparam int DEPTH = 2**FIFO_AW;

   localparam logic [FIFO_AW:0] C_DEPTH      = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0] C_PAY_LEN    = (FIFO_AW+1)'(PAYLOAD_LEN);
   localparam logic [FIFO_AW:0] C_PAY_LAST   = (FIFO_AW+1)'(PAYLOAD_LEN-1);
   localparam logic [FIFO_AW:0] C_PAY_PENULT = (FIFO_AW+1)'(PAYLOAD_LEN-2);
   localparam logic [3:0]       C_HDR_LAST   = 4'(HDR_LEN-1);

   generate
      if (PAYLOAD_LEN < 46 || PAYLOAD_LEN > DEPTH) begin : g_bad_payload_len
         $error("eth_frame_tx: PAYLOAD_LEN must lie in 46..2**FIFO_AW");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   state_t              state_q;
   logic [3:0]          hdr_idx_q;
   logic [FIFO_AW:0]    pay_idx_q;
   logic [7:0]          hdr_byte_q;
   logic                tvalid_q;
   logic                tlast_q;
   logic [15:0]         frame_count_q;
   logic                overflow_q;

   // ------------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------------
   logic [7:0]          mem [DEPTH];
   logic [7:0]          rd_data_q;
   logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]    count_q, count_d;
   logic                full;
   logic                wr_en;
   logic                pop;
   logic                frame_done;

   assign full       = (count_q == C_DEPTH);
   assign wr_en      = din_valid && !full;
   // tvalid is always high in PAYLOAD, so tready alone marks a handshake.
   assign pop        = (state_q == ST_PAYLOAD) && tx_axis_tready;
   assign frame_done = pop && (pay_idx_q == C_PAY_LAST);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Block-RAM style storage. The read address is the next-cycle head, so
   // rd_data_q always holds the current head byte and the read latency is
   // hidden. A frame only starts with a full payload already stored, so the
   // head is never the location being written while it is presented.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= din;
      end
      rd_data_q <= mem[rd_ptr_d];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (din_valid && full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Header bytes
   // ------------------------------------------------------------------------
   logic [HDR_LEN*8-1:0] hdr_vec;
   logic [HDR_LEN*8-1:0] hdr_shifted;
   logic [7:0]           hdr_first;
   logic [7:0]           hdr_next;

`ifdef ETH_FRAME_TX_SEQ_EN
   logic [15:0] seq_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq_q <= '0;
      end else if (frame_done) begin
         seq_q <= seq_q + 16'd1;
      end
   end

   assign hdr_vec = {DST_MAC, SRC_MAC, ETHERTYPE, seq_q};
`else
   assign hdr_vec = {DST_MAC, SRC_MAC, ETHERTYPE};
`endif

   // Byte following hdr_idx_q; shifting avoids an out-of-range part-select
   // on the last header byte (that result is never used).
   assign hdr_shifted = hdr_vec << {hdr_idx_q + 4'd1, 3'b000};
   assign hdr_first   = hdr_vec[HDR_LEN*8-1 -: 8];
   assign hdr_next    = hdr_shifted[HDR_LEN*8-1 -: 8];

   // ------------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         hdr_idx_q     <= '0;
         pay_idx_q     <= '0;
         hdr_byte_q    <= '0;
         tvalid_q      <= 1'b0;
         tlast_q       <= 1'b0;
         frame_count_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tvalid_q <= 1'b0;
               tlast_q  <= 1'b0;
               if (enable && (count_q >= C_PAY_LEN)) begin
                  state_q    <= ST_HEADER;
                  hdr_idx_q  <= '0;
                  hdr_byte_q <= hdr_first;
                  tvalid_q   <= 1'b1;
               end
            end
            ST_HEADER: begin
               if (tx_axis_tready) begin
                  if (hdr_idx_q == C_HDR_LAST) begin
                     state_q   <= ST_PAYLOAD;
                     pay_idx_q <= '0;
                     tlast_q   <= 1'b0;
                  end else begin
                     hdr_idx_q  <= hdr_idx_q + 4'd1;
                     hdr_byte_q <= hdr_next;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (tx_axis_tready) begin
                  if (pay_idx_q == C_PAY_LAST) begin
                     state_q       <= ST_IDLE;
                     tvalid_q      <= 1'b0;
                     tlast_q       <= 1'b0;
                     frame_count_q <= frame_count_q + 16'd1;
                  end else begin
                     pay_idx_q <= pay_idx_q + 1'b1;
                     tlast_q   <= (pay_idx_q == C_PAY_PENULT);
                  end
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               tvalid_q <= 1'b0;
               tlast_q  <= 1'b0;
            end
         endcase
      end
   end

   // Payload bytes come straight from the FIFO read register, which only
   // advances on a handshake, so tdata stays stable during stalls.
   assign tx_axis_tdata  = (state_q == ST_PAYLOAD) ? rd_data_q : hdr_byte_q;
   assign tx_axis_tvalid = tvalid_q;
   assign tx_axis_tlast  = tlast_q;
   assign tx_axis_tuser  = 1'b0;
   assign fifo_overflow  = overflow_q;
   assign frame_count    = frame_count_q;
   assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_frame_tx
// Purpose  : Self-checking bench for eth_frame_tx. Accepted input bytes go
//            into a scoreboard queue; a monitor pops them on every payload
//            handshake and compares header bytes against constants and a
//            model sequence counter. Define ETH_FRAME_TX_SEQ_EN for both
//            files to exercise the 16-byte header build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_frame_tx;

`ifdef ETH_FRAME_TX_SEQ_EN
   localparam int HDR = 16;
`else
   localparam int HDR = 14;
`endif
   localparam int PLEN  = 1024;
   localparam int DEPTH = 4096;
   localparam int FLEN  = HDR + PLEN;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        enable    = 1'b0;
   logic [7:0]  din       = 8'h00;
   logic        din_valid = 1'b0;
   logic        tready    = 1'b0;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tlast;
   logic        tuser;
   logic        overflow;
   logic [15:0] frame_count;
   logic        busy;

   eth_frame_tx dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .din            (din),
      .din_valid      (din_valid),
      .tx_axis_tdata  (tdata),
      .tx_axis_tvalid (tvalid),
      .tx_axis_tready (tready),
      .tx_axis_tlast  (tlast),
      .tx_axis_tuser  (tuser),
      .fifo_overflow  (overflow),
      .frame_count    (frame_count),
      .busy           (busy)
   );

   always #4 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  sb_q[$];
   int          beat   = 0;
   int          frames = 0;
   int          hs     = 0;
   logic [15:0] m_seq  = 16'h0000;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data  = 8'h00;
   logic        prev_last  = 1'b0;
   bit          gap_meas   = 1'b0;
   int          gap_cnt    = 0;
   int          last_gap   = -1;
   bit          rand_rdy   = 1'b0;
   logic [7:0]  exp_b;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] hdr_exp(input int i, input logic [15:0] s);
      if (i < 6)        return 8'hFF;
      else if (i == 6)  return 8'h02;
      else if (i < 11)  return 8'h00;
      else if (i == 11) return 8'h01;
      else if (i == 12) return 8'h88;
      else if (i == 13) return 8'hB5;
      else if (i == 14) return s[15:8];
      else              return s[7:0];
   endfunction

   // Output monitor / scoreboard consumer
   always @(negedge clk) begin
      if (!reset) begin
         if (prev_stall) begin
            check("stall_tvalid", tvalid, 1);
            check("stall_tdata", tdata, prev_data);
            check("stall_tlast", tlast, prev_last);
         end
         if (beat > 0) begin
            check("tvalid_continuous", tvalid, 1);
         end
         if (gap_meas) begin
            if (tvalid) begin
               last_gap = gap_cnt;
               gap_meas = 1'b0;
            end else begin
               gap_cnt++;
            end
         end
         if (tvalid && tready) begin
            if (beat < HDR) begin
               exp_b = hdr_exp(beat, m_seq);
            end else begin
               check("sb_nonempty", (sb_q.size() > 0), 1);
               exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
            end
            check("tdata", tdata, exp_b);
            check("tlast", tlast, (beat == FLEN-1));
            check("tuser", tuser, 0);
            hs++;
            beat++;
            if (beat == FLEN) begin
               beat     = 0;
               frames++;
               m_seq    = m_seq + 16'd1;
               gap_meas = 1'b1;
               gap_cnt  = 0;
            end
         end
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_rdy) tready = ($urandom_range(0, 1) == 1);
   endtask

   task automatic push(input logic [7:0] b);
      din       = b;
      din_valid = 1'b1;
      if (sb_q.size() < DEPTH) sb_q.push_back(b);
      step();
      din_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n = 0;
      while (frames < target && n < budget) begin
         step();
         n++;
      end
      check("frames_reached", frames, target);
   endtask

   initial begin
      int f0;
      int h0;
      int n;

      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check("rst_tvalid", tvalid, 0);
      check("rst_tlast", tlast, 0);
      check("rst_tdata", tdata, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      step();
      check("idle_tvalid", tvalid, 0);

      // Single frame, tready always high
      enable = 1'b1;
      tready = 1'b1;
      for (int i = 0; i < PLEN; i++) push(8'(i));
      step();
      step();
      check("t1_busy", busy, 1);
      wait_frames(1, 1200);
      step();
      check("t1_frame_count", frame_count, 1);
      check("t1_sb_empty", sb_q.size(), 0);
      check("t1_idle_busy", busy, 0);

      // Random backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < PLEN; i++) push(8'(i * 7 + 3));
      wait_frames(2, 5000);
      rand_rdy = 1'b0;
      tready   = 1'b1;
      step();
      check("t2_frame_count", frame_count, 2);

      // Two frames back to back, minimum inter-frame gap
      for (int i = 0; i < 2 * PLEN; i++) push(8'(i) ^ 8'h5A);
      wait_frames(4, 2000);
      step();
      check("t4_gap", last_gap, 1);
      check("t4_frame_count", frame_count, 4);

      // FIFO fill to full, then one dropped byte
      enable = 1'b0;
      for (int i = 0; i < DEPTH; i++) push(8'(i * 3));
      check("t3_no_overflow_at_full", overflow, 0);
      check("t3_no_frame_disabled", busy, 0);
      push(8'hEE);
      step();
      check("t3_overflow_set", overflow, 1);
      check("t3_sb_full", sb_q.size(), DEPTH);
      enable = 1'b1;
      wait_frames(8, 9000);
      step();
      check("t3_frame_count", frame_count, 8);
      check("t3_sb_empty", sb_q.size(), 0);
      check("t3_overflow_sticky", overflow, 1);

      // Reset in the middle of the payload
      for (int i = 0; i < PLEN; i++) push(8'(255 - i));
      n = 0;
      while (beat < HDR + 500 && n < 3000) begin
         step();
         n++;
      end
      check("t5_reach_beat500", beat, HDR + 500);
      reset = 1'b1;
      #1;
      check("t5_rst_tvalid", tvalid, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_frame_count", frame_count, 0);
      check("t5_rst_overflow", overflow, 0);
      sb_q.delete();
      beat       = 0;
      prev_stall = 1'b0;
      m_seq      = 16'h0000;
      gap_meas   = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      h0 = hs;
      for (int i = 0; i < PLEN - 1; i++) push(8'(i + 17));
      repeat (20) step();
      check("t5_no_output_partial", hs, h0);
      check("t5_tvalid_low", tvalid, 0);
      push(8'hC3);
      f0 = frames;
      wait_frames(f0 + 1, 1200);
      step();
      check("t5_frame_count", frame_count, 1);
      check("t5_sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
